// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU shift-path types and funct codes
// Contents:
//   shr_state_t  state encoding of the multi-cycle right shifter
//   FUNCT_*      R-type funct codes routed to the right-shift path
package mips_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } shr_state_t;

    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

endpackage

// File: rtl/shr_step.sv
// rtl/shr_step.sv - combinational single-step right shifter with fill
// Ports:
//   x     in   WIDTH             value to shift
//   n     in   $clog2(STEP+1)    shift distance, 0..STEP
//   fill  in   1                 bit shifted into the vacated MSBs
//   y     out  WIDTH             x >> n with the top n bits set to fill
module shr_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int NW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] x,
    input  logic [NW-1:0]    n,
    input  logic             fill,
    output logic [WIDTH-1:0] y
);

    // Prepending fill as a sign bit lets one arithmetic shift do both SRL
    // (fill=0) and SRA (fill=sign); the extra MSB is discarded.
    logic sh_unused_msb;

    assign {sh_unused_msb, y} = $signed({fill, x}) >>> n;

endmodule

// File: rtl/shr_multicycle.sv
// rtl/shr_multicycle.sv - multi-cycle right shifter for SRL/SRA/SRLV/SRAV
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only while busy==0
//   flush  in   1      synchronous abort, wins over start
//   a      in   WIDTH  operand
//   shamt  in   SHW    shift amount 0..WIDTH-1
//   arith  in   1      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy   out  1      operation in flight
//   done   out  1      one-cycle pulse, y valid in the same cycle
//   y      out  WIDTH  result, held until the next done
module shr_multicycle
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = 1,
    localparam int NW   = $clog2(STEP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    shr_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic [NW-1:0]    step_n;
    logic [SHW-1:0]   rem_after;
    logic [WIDTH-1:0] acc_shifted;

    // The last step may be partial: never shift further than what remains.
    always_comb begin
        step_n = NW'(STEP);
        if (rem_q < SHW'(STEP)) begin
            step_n = NW'(rem_q);
        end
    end

    assign rem_after = rem_q - SHW'(step_n);

    shr_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .x    (acc_q),
        .n    (step_n),
        .fill (fill_q),
        .y    (acc_shifted)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        y_d     = y_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    acc_d  = a;
                    rem_d  = shamt;
                    fill_d = arith & a[WIDTH-1];
                    if (shamt == '0) begin
                        // Nothing to shift: the result is ready next cycle.
                        state_d = DONE;
                        y_d     = a;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_shifted;
                rem_d = rem_after;
                if (rem_after == '0) begin
                    state_d = DONE;
                    y_d     = acc_shifted;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards the operation in flight and leaves y untouched.
        if (flush) begin
            state_d = IDLE;
            acc_d   = acc_q;
            rem_d   = rem_q;
            fill_d  = fill_q;
            y_d     = y_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign y    = y_q;

endmodule
